seq_mul16: RTL and testbench
============================

SEQ_MUL16 -- requirements
Module: seq_mul16

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; the result is 2*WIDTH bits.
REQ-002 Clock  input  1  the single clock; all state is updated on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 iStart  input  1  start request; it is sampled only in IDLE.
REQ-005 iA  input  WIDTH  multiplicand, captured when a start is accepted.
REQ-006 iB  input  WIDTH  multiplier, captured when a start is accepted.
REQ-007 oBusy  output  1  high in the RUN and DONE states.
REQ-008 oDone  output  1  one-cycle pulse, high only in the DONE state.
REQ-009 oResultLo  output  WIDTH  product bits [WIDTH-1:0], for the RAM data write port.
REQ-010 oResultHi  output  WIDTH  product bits [2*WIDTH-1:WIDTH], for the RAM high-word port.

Function
REQ-011 The block SHALL be an iterative shift-add multiplier with three states: IDLE, RUN and DONE.
REQ-012 In IDLE, a rising edge with iStart=1 SHALL capture iA and iB, clear the accumulator, clear the iteration counter and enter RUN.
REQ-013 RUN SHALL perform exactly one multiplier-bit iteration per clock, for exactly WIDTH clocks, then enter DONE.
REQ-014 DONE SHALL last exactly one clock and then return to IDLE unconditionally.
REQ-015 oDone SHALL go high WIDTH+1 rising edges after the start-sampling edge; for WIDTH=16 that is 17 cycles.
REQ-016 oResultHi/oResultLo SHALL be registered and SHALL update with the final product on entry to DONE.
REQ-017 oResultHi/oResultLo SHALL hold that product until the next accepted start; intermediate accumulator values SHALL never appear on them.
REQ-018 iStart in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-019 A start is accepted on the first IDLE edge with iStart=1, so back-to-back operations have a 1-cycle IDLE gap minimum.
REQ-020 Changes on iA/iB after capture SHALL NOT affect the operation in progress.
REQ-021 The product SHALL be exact across the full operand range, with no truncation or saturation; the internal accumulator is at least WIDTH+1 bits wide.
REQ-022 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-023 Reset low SHALL immediately force: IDLE, oBusy=0, oDone=0, oResultHi=0, oResultLo=0, counter=0, accumulator=0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the operation without producing an oDone pulse.
REQ-025 After reset deassertion the block SHALL accept a start on the first rising edge.

Configuration
REQ-026 With macro SEQ_MUL_SIGNED_EN defined, operands SHALL be two's complement and the product signed, using radix-2 Booth recoding with an arithmetic shift.
REQ-027 Without SEQ_MUL_SIGNED_EN, operands SHALL be unsigned and the product unsigned, using plain shift-add with a logical shift.
REQ-028 Latency, handshake and port list SHALL be identical in both builds.

Verification
REQ-029 Any build, A=3, B=5, start pulse -> oDone on cycle 17; Hi=0x0000, Lo=0x000F; oBusy high for 17 cycles.
REQ-030 Signed build: A=0xFFFE (-2), B=0x0003 -> Hi=0xFFFF, Lo=0xFFFA.
REQ-031 Signed build: A=B=0x8000 -> Hi=0x4000, Lo=0x0000.
REQ-032 Unsigned build: A=B=0xFFFF -> Hi=0xFFFE, Lo=0x0001.
REQ-033 Start A=7, B=9, then iStart=1 with A=2, B=2 at cycle 5 -> single oDone; result 0x0000_003F; the second request is not executed.
REQ-034 Start A=7, B=9, Reset low at cycle 8 for 1 cycle, then start A=4, B=4 -> no oDone for the first operation; outputs 0 after reset; second result 0x0000_0010 at 17 cycles.

Source files
------------

// File: rtl/seq_mul16.sv
// rtl/seq_mul16.sv - iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH
// Build option: define SEQ_MUL_SIGNED_EN for two's-complement operands (radix-2 Booth),
// otherwise operands are unsigned (plain shift-add).
module seq_mul16 #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLo,
  output logic [WIDTH-1:0] oResultHi
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  // Upper partial product carries one guard bit so no add/subtract can overflow.
  logic [WIDTH:0]   acc_q, acc_d;
  // Multiplier register; it shifts out consumed bits and fills with product low bits.
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  logic             last_iter;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_mplr;

  // The counter stops at WIDTH-1; the iteration at that value is the final one.
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

`ifdef SEQ_MUL_SIGNED_EN
  logic           qm1_q, qm1_d;
  logic [WIDTH:0] a_ext;

  assign a_ext = {a_q[WIDTH-1], a_q};

  // Booth step: the bit pair {q0, q-1} selects +A, -A or nothing, then arithmetic shift.
  always_comb begin
    sum = acc_q;
    case ({mplr_q[0], qm1_q})
      2'b01:   sum = acc_q + a_ext;
      2'b10:   sum = acc_q - a_ext;
      default: sum = acc_q;
    endcase
    step_acc  = {sum[WIDTH], sum[WIDTH:1]};
    step_mplr = {sum[0], mplr_q[WIDTH-1:1]};
  end
`else
  // Shift-add step: add A when the current multiplier bit is set, then logical shift.
  always_comb begin
    sum       = acc_q + (mplr_q[0] ? {1'b0, a_q} : {(WIDTH + 1){1'b0}});
    step_acc  = {1'b0, sum[WIDTH:1]};
    step_mplr = {sum[0], mplr_q[WIDTH-1:1]};
  end
`endif

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start is only looked at in IDLE, DONE always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iStart) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state register.
  always_comb begin
    oBusy = 1'b0;
    oDone = 1'b0;
    case (state_q)
      S_RUN:   oBusy = 1'b1;
      S_DONE:  begin
        oBusy = 1'b1;
        oDone = 1'b1;
      end
      default: begin
        oBusy = 1'b0;
        oDone = 1'b0;
      end
    endcase
  end

  // Datapath next state: capture on start, iterate in RUN, publish result on the last step.
  always_comb begin
    cnt_d    = cnt_q;
    a_d      = a_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
`ifdef SEQ_MUL_SIGNED_EN
    qm1_d    = qm1_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          a_d    = iA;
          mplr_d = iB;
          acc_d  = '0;
          cnt_d  = '0;
`ifdef SEQ_MUL_SIGNED_EN
          qm1_d  = 1'b0;
`endif
        end
      end
      S_RUN: begin
        acc_d  = step_acc;
        mplr_d = step_mplr;
`ifdef SEQ_MUL_SIGNED_EN
        qm1_d  = mplr_q[0];
`endif
        if (last_iter) begin
          res_lo_d = step_mplr;
          res_hi_d = step_acc[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything so an aborted operation leaves no trace.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
`ifdef SEQ_MUL_SIGNED_EN
      qm1_q    <= qm1_d;
`endif
    end
  end

  assign oResultLo = res_lo_q;
  assign oResultHi = res_hi_q;

endmodule

// File: tb/tb_seq_mul16.sv
// tb/tb_seq_mul16.sv - directed bench for seq_mul16
module tb_seq_mul16;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oResultLo;
  logic [15:0] oResultHi;

  int total;
  int bad;

  seq_mul16 #(.WIDTH(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iA        (iA),
    .iB        (iB),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResultLo (oResultLo),
    .oResultHi (oResultHi)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Runs one operation in a fixed 30-cycle window. n counts rising edges with the
  // start-sampling edge as 1; outputs are sampled on the falling edge after edge n.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input int poke_at, input int rst_at,
                       output int lat, output int busy_cnt, output int done_cnt);
    lat      = 0;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge Clock);
    iA     = a;
    iB     = b;
    iStart = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (oBusy) busy_cnt++;
      if (oDone) begin
        done_cnt++;
        if (lat == 0) lat = n;
      end
      if (n == rst_at + 1) Reset = 1'b1;
      if (n == poke_at) begin
        iStart = 1'b1;
        iA     = 16'd2;
        iB     = 16'd2;
      end else begin
        iStart = 1'b0;
        iA     = 16'hA5A5;
        iB     = 16'h5A5A;
      end
      if (n == rst_at) begin
        Reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_mid_done", {31'd0, oDone}, 32'd0);
        chk("rst_mid_res", {oResultHi, oResultLo}, 32'd0);
      end
    end
  endtask

  int lat;
  int busy_cnt;
  int done_cnt;

  initial begin
    total  = 0;
    bad    = 0;
    Reset  = 1'b0;
    iStart = 1'b0;
    iA     = 16'd0;
    iB     = 16'd0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    chk("reset_busy", {31'd0, oBusy}, 32'd0);
    chk("reset_done", {31'd0, oDone}, 32'd0);
    chk("reset_res", {oResultHi, oResultLo}, 32'd0);
    Reset = 1'b1;

    do_op(16'd3, 16'd5, 0, 0, lat, busy_cnt, done_cnt);
    chk("3x5_lat", lat, 17);
    chk("3x5_busy", busy_cnt, 17);
    chk("3x5_ndone", done_cnt, 1);
    chk("3x5_res", {oResultHi, oResultLo}, 32'h0000_000F);

`ifdef SEQ_MUL_SIGNED_EN
    do_op(16'hFFFE, 16'h0003, 0, 0, lat, busy_cnt, done_cnt);
    chk("m2x3_lat", lat, 17);
    chk("m2x3_res", {oResultHi, oResultLo}, 32'hFFFF_FFFA);
    do_op(16'h8000, 16'h8000, 0, 0, lat, busy_cnt, done_cnt);
    chk("min_sq_lat", lat, 17);
    chk("min_sq_res", {oResultHi, oResultLo}, 32'h4000_0000);
`else
    do_op(16'hFFFF, 16'hFFFF, 0, 0, lat, busy_cnt, done_cnt);
    chk("max_sq_lat", lat, 17);
    chk("max_sq_busy", busy_cnt, 17);
    chk("max_sq_res", {oResultHi, oResultLo}, 32'hFFFE_0001);
    do_op(16'h8001, 16'h0002, 0, 0, lat, busy_cnt, done_cnt);
    chk("u_8001x2_res", {oResultHi, oResultLo}, 32'h0001_0002);
`endif

    do_op(16'd7, 16'd9, 5, 0, lat, busy_cnt, done_cnt);
    chk("ign_ndone", done_cnt, 1);
    chk("ign_lat", lat, 17);
    chk("ign_busy", busy_cnt, 17);
    chk("ign_res", {oResultHi, oResultLo}, 32'h0000_003F);

    do_op(16'd7, 16'd9, 0, 8, lat, busy_cnt, done_cnt);
    chk("abort_ndone", done_cnt, 0);
    chk("abort_res", {oResultHi, oResultLo}, 32'd0);

    do_op(16'd4, 16'd4, 0, 0, lat, busy_cnt, done_cnt);
    chk("4x4_lat", lat, 17);
    chk("4x4_res", {oResultHi, oResultLo}, 32'h0000_0010);

    // Start held high: the next operation must begin on the first IDLE edge.
    @(negedge Clock);
    iA     = 16'd2;
    iB     = 16'd3;
    iStart = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (n == 17) chk("b2b_done", {31'd0, oDone}, 32'd1);
      if (n == 18) chk("b2b_gap", {31'd0, oBusy}, 32'd0);
      if (n == 19) chk("b2b_restart", {31'd0, oBusy}, 32'd1);
    end
    iStart = 1'b0;
    chk("b2b_res", {oResultHi, oResultLo}, 32'h0000_0006);
    repeat (20) @(posedge Clock);
    @(negedge Clock);
    chk("b2b_idle", {31'd0, oBusy}, 32'd0);
    chk("b2b_res2", {oResultHi, oResultLo}, 32'h0000_0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
